// File: rtl/downsampler2.sv
// Streaming 2x2 box-filter decimator: one rounded-average pixel per 2x2 block,
// written to an external FIFO; a dropped write sets a sticky overflow flag.
module downsampler2 #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  input  logic       fifo_full,
  output logic [7:0] dataout,
  output logic       validout,
  output logic       overflow,
  output logic [9:0] current_colcount,
  output logic [9:0] current_rowcount
);

  localparam int HALF = WIDTH / 2;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [9:0] COL_LAST = 10'(WIDTH - 1);
  localparam logic [9:0] ROW_LAST = 10'(HEIGHT - 1);

  logic [9:0]    col_r;
  logic [9:0]    row_r;
  logic [7:0]    hold_r;
  logic [8:0]    line_buf_r [HALF];
  logic [7:0]    dataout_r;
  logic          validout_r;
  logic          overflow_r;

  logic [9:0]    col_next_s;
  logic [9:0]    row_next_s;
  logic [AW-1:0] buf_idx_s;
  logic [8:0]    hsum_s;
  logic [9:0]    total_s;
  logic [7:0]    avg_s;
  logic          out_slot_s;
  logic          buf_wr_s;

  // Next raster position, pair sums and the rounded block average.
  always_comb begin
    col_next_s = col_r;
    row_next_s = row_r;
    if (col_r == COL_LAST) begin
      col_next_s = 10'd0;
      if (row_r == ROW_LAST) begin
        row_next_s = 10'd0;
      end else begin
        row_next_s = row_r + 10'd1;
      end
    end else begin
      col_next_s = col_r + 10'd1;
    end
    buf_idx_s  = col_r[AW:1];
    hsum_s     = {1'b0, hold_r} + {1'b0, data};
    total_s    = {1'b0, line_buf_r[buf_idx_s]} + {1'b0, hsum_s};
    // Sum of four 8-bit pixels plus 2 never exceeds 1022, so 10 bits cannot wrap.
    avg_s      = 8'((total_s + 10'd2) >> 2);
    out_slot_s = valid & col_r[0] & row_r[0];
    buf_wr_s   = valid & col_r[0] & ~row_r[0];
  end

  // Position counters, horizontal hold register and output/overflow registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_r      <= 10'd0;
      row_r      <= 10'd0;
      hold_r     <= 8'd0;
      dataout_r  <= 8'd0;
      validout_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (valid) begin
        col_r <= col_next_s;
        row_r <= row_next_s;
        if (!col_r[0]) begin
          hold_r <= data;
        end
      end
      validout_r <= out_slot_s & ~fifo_full;
      if (out_slot_s && !fifo_full) begin
        dataout_r <= avg_s;
      end
      if (out_slot_s && fifo_full) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Even-row pair sums; contents persist across reset and are rewritten every even row.
  always_ff @(posedge clock) begin
    if (!reset && buf_wr_s) begin
      line_buf_r[buf_idx_s] <= hsum_s;
    end
  end

  assign dataout          = dataout_r;
  assign validout         = validout_r;
  assign overflow         = overflow_r;
  assign current_colcount = col_r;
  assign current_rowcount = row_r;

endmodule

// File: tb/tb_downsampler2.sv
// Randomized self-checking bench for downsampler2 on a reduced 300x6 frame,
// checked against a pixel-array reference model of the 2x2 averaging rules.
module tb_downsampler2;

  localparam int W    = 300;
  localparam int H    = 6;
  localparam int NOUT = (W / 2) * (H / 2);

  logic       clock = 1'b0;
  logic       reset;
  logic       valid;
  logic [7:0] data;
  logic       fifo_full;
  logic [7:0] dataout;
  logic       validout;
  logic       overflow;
  logic [9:0] current_colcount;
  logic [9:0] current_rowcount;

  downsampler2 #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock            (clock),
    .reset            (reset),
    .valid            (valid),
    .data             (data),
    .fifo_full        (fifo_full),
    .dataout          (dataout),
    .validout         (validout),
    .overflow         (overflow),
    .current_colcount (current_colcount),
    .current_rowcount (current_rowcount)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int frame_pix [H][W];
  int pos      = 0;
  bit exp_vo   = 1'b0;
  bit exp_ovf  = 1'b0;
  int exp_do   = 0;
  int obs_q [$];
  int strobes  = 0;
  int cval     = 0;
  int ra, rb, rc, rd;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (pos %0d)", tag, obs, exp, pos);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit v, input int d, input bit full, input bit rst);
    int r, c, s;
    reset     = rst;
    valid     = v;
    data      = 8'(d);
    fifo_full = full;
    exp_vo    = 1'b0;
    if (rst) begin
      pos     = 0;
      exp_ovf = 1'b0;
      exp_do  = 0;
    end else if (v) begin
      r = pos / W;
      c = pos % W;
      frame_pix[r][c] = d & 255;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        s = frame_pix[r-1][c-1] + frame_pix[r-1][c] + frame_pix[r][c-1] + frame_pix[r][c];
        if (full) begin
          exp_ovf = 1'b1;
        end else begin
          exp_vo = 1'b1;
          exp_do = (s + 2) / 4;
        end
      end
      pos = (pos + 1) % (W * H);
    end
    @(posedge clock);
    #1;
    check("validout", validout, exp_vo);
    check("overflow", overflow, exp_ovf);
    check("colcount", current_colcount, pos % W);
    check("rowcount", current_rowcount, pos / W);
    if (exp_vo) check("dataout", dataout, exp_do);
    if (validout) begin
      obs_q.push_back(int'(dataout));
      strobes++;
    end
  endtask

  function automatic int pix(input int mode, input int r, input int c);
    case (mode)
      0: return cval;
      1: return c % 256;
      2: begin
        if (r == 2 && c == 4) return ra;
        if (r == 2 && c == 5) return rb;
        if (r == 3 && c == 4) return rc;
        if (r == 3 && c == 5) return rd;
        return 0;
      end
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // mode: 0 const, 1 column ramp, 2 single block, 3 random; gap: valid every gap-th cycle.
  task automatic send_frame(input int mode, input int gap, input int full_out);
    int idle, p;
    bit full;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        idle = (mode == 3) ? int'($urandom_range(0, 2)) : gap - 1;
        for (int i = 0; i < idle; i++)
          cycle(1'b0, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        p = pix(mode, r, c);
        full = (r % 2 == 1) && (c % 2 == 1) && (((r / 2) * (W / 2) + c / 2) == full_out);
        if (mode == 3 && $urandom_range(0, 49) == 0) full = 1'b1;
        cycle(1'b1, p, full, 1'b0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; data = 8'd0; fifo_full = 1'b0;
    cycle(1'b1, 123, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b1);
    check("rst_validout", validout, 0);
    check("rst_dataout", dataout, 0);
    check("rst_overflow", overflow, 0);
    check("rst_col", current_colcount, 0);
    check("rst_row", current_rowcount, 0);

    // constant frame
    cval = 100; obs_q.delete(); strobes = 0;
    send_frame(0, 1, -1);
    check("const_strobes", strobes, NOUT);
    foreach (obs_q[i]) check("const_val", obs_q[i], 100);

    // single-block rounding cases
    for (int k = 0; k < 4; k++) begin
      int rexp;
      case (k)
        0: begin ra = 0;   rb = 0;   rc = 0;   rd = 1;   rexp = 0;   end
        1: begin ra = 1;   rb = 1;   rc = 1;   rd = 0;   rexp = 1;   end
        2: begin ra = 1;   rb = 1;   rc = 0;   rd = 0;   rexp = 1;   end
        default: begin ra = 255; rb = 255; rc = 255; rd = 255; rexp = 255; end
      endcase
      obs_q.delete();
      send_frame(2, 1, -1);
      check("round_n", obs_q.size(), NOUT);
      if (obs_q.size() > W / 2 + 2) check("round_val", obs_q[W/2+2], rexp);
    end

    // column ramp, continuous then valid every third cycle
    for (int g = 1; g <= 3; g += 2) begin
      obs_q.delete(); strobes = 0;
      send_frame(1, g, -1);
      check("ramp_strobes", strobes, NOUT);
      foreach (obs_q[i]) check("ramp_val", obs_q[i], ((2 * (i % (W / 2))) % 256) + 1);
    end

    // FIFO full on the fifth output
    obs_q.delete(); strobes = 0;
    send_frame(1, 1, 4);
    check("ovf_strobes", strobes, NOUT - 1);
    check("ovf_flag", overflow, 1);
    if (obs_q.size() > 4) check("ovf_next_val", obs_q[4], 11);

    // reset at row 3 col 10, then a fresh frame of 50
    for (int i = 0; i < 3 * W + 10; i++) cycle(1'b1, 77, 1'b0, 1'b0);
    cycle(1'b1, 9, 1'b0, 1'b1);
    check("mid_rst_col", current_colcount, 0);
    check("mid_rst_row", current_rowcount, 0);
    check("mid_rst_ovf", overflow, 0);
    cval = 50; obs_q.delete(); strobes = 0;
    send_frame(0, 1, -1);
    check("mid_strobes", strobes, NOUT);
    foreach (obs_q[i]) check("mid_val", obs_q[i], 50);
    check("mid_ovf_end", overflow, 0);

    // random pixels, gaps and FIFO-full events
    send_frame(3, 1, -1);
    send_frame(3, 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
